// File: rtl/addsub_pipe.sv
// Pipelined adder-subtractor: the carry chain is cut into STAGES segments, one register per segment,
// with valid/ready on both sides. Define ADDSUB_STICKY_OVF_EN to add the sticky overflow flag (ovf_clr/ovf_sticky).
module addsub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ADDSUB_STICKY_OVF_EN
    input  logic             ovf_clr,
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("addsub_pipe: WIDTH must be a positive multiple of STAGES");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [STAGES:0]   v_up;

    assign v_up = {v, in_valid};

    // Backpressure ripples from out_ready toward the input in the same cycle, so a full pipe still streams.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = ~v[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = ~v[k] | adv[k+1];
        end
    end

    assign load      = adv & v_up[STAGES-1:0];
    assign in_ready  = ~v[0] | adv[0];
    assign out_valid = v[STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v <= '0;
        end else begin
            v <= load | (v & ~adv);
        end
    end

    // Stage k adds segment k; the operand bits still to be added shrink by SEG per stage
    // while the completed result bits grow by SEG.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM = WIDTH - k * SEG;
        localparam int LO  = k * SEG;

        logic [REM-1:0]    op_a;
        logic [REM-1:0]    op_b;
        logic [LO+SEG-1:0] done;
        logic              c_in;
        logic              sat_in;
        logic              a_msb;
        logic              b_msb;
        logic [SEG:0]      seg_sum;

        if (k == 0) begin : g_src
            assign op_a   = a;
            assign op_b   = b ^ {WIDTH{sub}};
            assign c_in   = sub;
            assign sat_in = sat;
            assign a_msb  = a[WIDTH-1];
            assign b_msb  = b[WIDTH-1] ^ sub;
            assign done   = seg_sum[SEG-1:0];
        end else begin : g_src
            assign op_a   = g_stage[k-1].g_pass.a_q;
            assign op_b   = g_stage[k-1].g_pass.b_q;
            assign c_in   = g_stage[k-1].g_pass.c_q;
            assign sat_in = g_stage[k-1].g_pass.sat_q;
            assign a_msb  = g_stage[k-1].g_pass.a_msb_q;
            assign b_msb  = g_stage[k-1].g_pass.b_msb_q;
            assign done   = {seg_sum[SEG-1:0], g_stage[k-1].g_pass.lo_q};
        end

        assign seg_sum = {1'b0, op_a[SEG-1:0]} + {1'b0, op_b[SEG-1:0]} + {{SEG{1'b0}}, c_in};

        if (k < STAGES - 1) begin : g_pass
            logic [REM-SEG-1:0] a_q;
            logic [REM-SEG-1:0] b_q;
            logic [LO+SEG-1:0]  lo_q;
            logic               c_q;
            logic               sat_q;
            logic               a_msb_q;
            logic               b_msb_q;

            always_ff @(posedge clk) begin
                if (load[k]) begin
                    a_q     <= op_a[REM-1:SEG];
                    b_q     <= op_b[REM-1:SEG];
                    lo_q    <= done;
                    c_q     <= seg_sum[SEG];
                    sat_q   <= sat_in;
                    a_msb_q <= a_msb;
                    b_msb_q <= b_msb;
                end
            end
        end else begin : g_last
            logic             ovf_raw;
            logic [WIDTH-1:0] sat_val;

            assign ovf_raw = (a_msb == b_msb) & (done[WIDTH-1] != a_msb);
            assign sat_val = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

            // Output register only moves on a real load, so a stalled result stays put.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sum  <= '0;
                    cout <= 1'b0;
                    ovf  <= 1'b0;
                end else if (load[k]) begin
                    sum  <= (sat_in & ovf_raw) ? sat_val : done;
                    cout <= seg_sum[SEG];
                    ovf  <= ovf_raw;
                end
            end
        end
    end

`ifdef ADDSUB_STICKY_OVF_EN
    // Set has priority over clear so an overflow leaving in the clearing cycle is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid & out_ready & ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end
`endif

endmodule
